// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, debounce state encoding and key map
// Contents:
//   KEY_0..KEY_9, KEY_A, KEY_B, KEY_C, KEY_P, NO_KEY  4-bit key codes
//   db_state_t                                         one-hot debounce states
//   key_map(row, col)                                  matrix position to key code
//   is_seq_key(code)                                   key that extends a code sequence
package keypad_pkg;

  localparam logic [3:0] KEY_0  = 4'h0;
  localparam logic [3:0] KEY_1  = 4'h1;
  localparam logic [3:0] KEY_2  = 4'h2;
  localparam logic [3:0] KEY_3  = 4'h3;
  localparam logic [3:0] KEY_4  = 4'h4;
  localparam logic [3:0] KEY_5  = 4'h5;
  localparam logic [3:0] KEY_6  = 4'h6;
  localparam logic [3:0] KEY_7  = 4'h7;
  localparam logic [3:0] KEY_8  = 4'h8;
  localparam logic [3:0] KEY_9  = 4'h9;
  localparam logic [3:0] KEY_A  = 4'hA;
  localparam logic [3:0] KEY_B  = 4'hB;
  localparam logic [3:0] KEY_C  = 4'hC;
  localparam logic [3:0] KEY_P  = 4'hD;
  localparam logic [3:0] NO_KEY = 4'hF;

  // Matrix positions 0..13 (row*4+col) carry keys; r3c2 and r3c3 are empty.
  localparam int POPULATED_KEYS = 14;

  typedef enum logic [2:0] {
    DB_RELEASED  = 3'b001,
    DB_CANDIDATE = 3'b010,
    DB_HELD      = 3'b100
  } db_state_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'h0:    k = KEY_1;
      4'h1:    k = KEY_2;
      4'h2:    k = KEY_3;
      4'h3:    k = KEY_A;
      4'h4:    k = KEY_4;
      4'h5:    k = KEY_5;
      4'h6:    k = KEY_6;
      4'h7:    k = KEY_B;
      4'h8:    k = KEY_7;
      4'h9:    k = KEY_8;
      4'hA:    k = KEY_9;
      4'hB:    k = KEY_C;
      4'hC:    k = KEY_P;
      4'hD:    k = KEY_0;
      default: k = NO_KEY;
    endcase
    return k;
  endfunction

  // Digits, A and B build up a sequence; C and P close it.
  function automatic logic is_seq_key(input logic [3:0] k);
    return !(k == KEY_C || k == KEY_P);
  endfunction

endpackage

// File: rtl/keypad_timeout_timer.sv
// rtl/keypad_timeout_timer.sv - inter-key timeout timer with sequence arming
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   restart     sequence key accepted: arm (unless sequence complete), timer to 0
//   disarm      C or P accepted: disarm, clear timer and sequence count
//   timeout     one-cycle pulse when armed timer reaches TIMEOUT_CYCLES-1
import keypad_pkg::*;

module keypad_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SEQ_KEYS       = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic disarm,
  output logic timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(SEQ_KEYS + 1);

  logic [TW-1:0] timer;
  logic [SW-1:0] seq_cnt;
  logic          armed;

  // restart is the accept decision, one cycle ahead of the code output, so the
  // registered pulse lands exactly TIMEOUT_CYCLES after the code cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer   <= '0;
      seq_cnt <= '0;
      armed   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (restart) begin
        // Restart has priority over a simultaneous expiry.
        timer <= '0;
        if (seq_cnt == SW'(SEQ_KEYS - 1)) begin
          armed   <= 1'b0;
          seq_cnt <= '0;
        end else begin
          armed   <= 1'b1;
          seq_cnt <= seq_cnt + SW'(1);
        end
      end else if (disarm) begin
        armed   <= 1'b0;
        timer   <= '0;
        seq_cnt <= '0;
      end else if (armed) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout <= 1'b1;
          armed   <= 1'b0;
          timer   <= '0;
          seq_cnt <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce, key code and timeout generation
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   col_n[3:0]  keypad columns, active-low, asynchronous
//   row_n[3:0]  row drive, one-hot-low
//   code[3:0]   key code for one cycle per accepted press, else NO_KEY
//   key_valid   high when code != NO_KEY
//   timeout     one-cycle inter-key timeout pulse
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] code,
  output logic       key_valid,
  output logic       timeout
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]       col_meta, col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic [15:0]      snap, snap_next;
  logic             slot_end, scan_end;
  logic [3:0]       n_keys;
  logic [3:0]       single_code;
  logic             is_none, is_single, is_multi;
  db_state_t        state;
  logic [CNT_W-1:0] match_cnt;
  logic [3:0]       cand;
  logic             emit_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  assign slot_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_end = slot_end && (row_idx == 2'd3);

  // Snapshot with the current row slice inserted, so the row-3 sample taken
  // in the evaluation cycle is already part of what gets classified.
  always_comb begin
    snap_next = snap;
    snap_next[{row_idx, 2'b00} +: 4] = ~col_sync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
      row_n   <= 4'b1110;
      snap    <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      row_idx <= row_idx + 2'd1;
      row_n   <= ~(4'b0001 << (row_idx + 2'd1));
      snap    <= snap_next;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Classify populated positions only; r3c2/r3c3 never count.
  always_comb begin
    n_keys      = '0;
    single_code = NO_KEY;
    for (int i = 0; i < POPULATED_KEYS; i++) begin
      if (snap_next[i]) begin
        n_keys      = n_keys + 4'd1;
        single_code = key_map(2'(i / 4), 2'(i % 4));
      end
    end
  end

  assign is_none   = (n_keys == 4'd0);
  assign is_single = (n_keys == 4'd1);
  assign is_multi  = !is_none && !is_single;

  always_comb begin
    emit_now = 1'b0;
    if (scan_end && is_single) begin
      if (state == DB_RELEASED && DEBOUNCE_SCANS == 1)
        emit_now = 1'b1;
      else if (state == DB_CANDIDATE && single_code == cand &&
               match_cnt == CNT_W'(DEBOUNCE_SCANS - 1))
        emit_now = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DB_RELEASED;
      match_cnt <= '0;
      cand      <= NO_KEY;
      code      <= NO_KEY;
      key_valid <= 1'b0;
    end else begin
      code      <= NO_KEY;
      key_valid <= 1'b0;
      if (emit_now) begin
        code      <= single_code;
        key_valid <= 1'b1;
      end
      if (scan_end) begin
        case (state)
          DB_RELEASED: begin
            if (is_multi || emit_now) begin
              state     <= DB_HELD;
              match_cnt <= '0;
            end else if (is_single) begin
              state     <= DB_CANDIDATE;
              cand      <= single_code;
              match_cnt <= CNT_W'(1);
            end
          end
          DB_CANDIDATE: begin
            if (emit_now) begin
              state     <= DB_HELD;
              match_cnt <= '0;
            end else if (is_single && single_code == cand) begin
              match_cnt <= match_cnt + CNT_W'(1);
            end else begin
              state     <= DB_RELEASED;
              match_cnt <= '0;
            end
          end
          DB_HELD: begin
            // match_cnt counts consecutive empty scans here.
            if (!is_none) begin
              match_cnt <= '0;
            end else if (match_cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              state     <= DB_RELEASED;
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + CNT_W'(1);
            end
          end
          default: begin
            state     <= DB_RELEASED;
            match_cnt <= '0;
          end
        endcase
      end
    end
  end

  keypad_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SEQ_KEYS       (5)
  ) u_timeout_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (emit_now && is_seq_key(single_code)),
    .disarm  (emit_now && !is_seq_key(single_code)),
    .timeout (timeout)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int LATENCY        = DEBOUNCE_SCANS * 4 * SCAN_DIV; // index of code cycle, cycle 0 = first post-reset cycle
  localparam logic [3:0] NOKEY  = 4'hF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] code;
  logic       key_valid;
  logic       timeout;

  logic [15:0] pressed = '0;   // bit row*4+col

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int last_key_cyc = 0;

  logic [3:0] exp_q[$];
  int         to_q[$];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .code      (code),
    .key_valid (key_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive keypad: a pressed key shorts its row to its column.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid || code != NOKEY) begin
        check("kv_code_agree", int'(key_valid), int'(code != NOKEY));
        if (exp_q.size() == 0) begin
          check("unexpected_key", int'(code), int'(NOKEY));
        end else begin
          check("key_code", int'(code), int'(exp_q.pop_front()));
          last_key_cyc = cyc;
        end
      end
      if (timeout) begin
        if (to_q.size() == 0) check("unexpected_timeout", int'(timeout), 0);
        else check("timeout_cycle", cyc, to_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_row_n", int'(row_n), 4'b1110);
    check("rst_code", int'(code), int'(NOKEY));
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_keys(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int pos, input logic [3:0] k, input string tag);
    pressed = 16'd1 << pos;
    exp_q.push_back(k);
    wait_keys(tag);
    idle(40);
    pressed = '0;
    idle(80);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1);
  end

  initial begin
    // 1: key 4 held from reset; one pulse at the expected latency, then silence
    pressed = 16'd1 << 4;
    exp_q.push_back(4'h4);
    do_reset();
    wait_keys("t1_key4_seen");
    check("t1_latency", last_key_cyc - rel_cyc, LATENCY);
    idle(100);
    pressed = '0;
    idle(80);

    // 2: key 8 bouncing once per scan period, then stable
    do_reset();
    exp_q.push_back(4'h8);
    for (int i = 0; i < 4; i++) begin
      pressed = (i % 2 == 0) ? (16'd1 << 9) : 16'd0;
      idle(16);
    end
    check("t2_no_emit_during_bounce", exp_q.size(), 1);
    pressed = 16'd1 << 9;
    wait_keys("t2_key8_seen");
    idle(40);
    pressed = '0;
    idle(80);

    // 3: five-key sequence, no timeout afterwards
    do_reset();
    tap(1,  4'h2, "t3_key2");
    tap(9,  4'h8, "t3_key8");
    tap(7,  4'hB, "t3_keyB");
    tap(13, 4'h0, "t3_key0");
    tap(4,  4'h4, "t3_key4");
    idle(300);

    // 4: single key then idle: exactly one timeout
    do_reset();
    pressed = 16'd1 << 1;
    exp_q.push_back(4'h2);
    wait_keys("t4_key2");
    to_q.push_back(last_key_cyc + TIMEOUT_CYCLES);
    idle(20);
    pressed = '0;
    idle(250);
    check("t4_timeout_seen", to_q.size(), 0);
    to_q.delete();
    idle(250);

    // 5: two keys together ignored, then C; C never arms
    do_reset();
    pressed = 16'b11;
    idle(80);
    pressed = '0;
    idle(80);
    tap(11, 4'hC, "t5_keyC");
    idle(250);

    // 6: unpopulated key ignored; reset during a press of 9
    do_reset();
    pressed = 16'd1 << 14;
    idle(100);
    pressed = '0;
    idle(80);
    pressed = 16'd1 << 10;
    exp_q.push_back(4'h9);
    idle(24);
    do_reset();
    wait_keys("t6_key9_after_reset");
    check("t6_latency", last_key_cyc - rel_cyc, LATENCY);
    idle(40);
    pressed = '0;
    idle(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
